// File: rtl/control_leer_pkg.sv
// Shared definitions for the RTC read sequencer: FSM encoding, register indices, RTC addresses.
package control_leer_pkg;

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned ADDR_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        LOAD  = 3'd3,
        DONE  = 3'd4,
        ABORT = 3'd5
    } state_t;

    // Register-file indices (clock/date first, timer last)
    localparam logic [IDX_W-1:0] IDX_SEG   = 4'd0;
    localparam logic [IDX_W-1:0] IDX_MIN   = 4'd1;
    localparam logic [IDX_W-1:0] IDX_HORA  = 4'd2;
    localparam logic [IDX_W-1:0] IDX_DIA   = 4'd3;
    localparam logic [IDX_W-1:0] IDX_MES   = 4'd4;
    localparam logic [IDX_W-1:0] IDX_ANIO  = 4'd5;
    localparam logic [IDX_W-1:0] IDX_TSEG  = 4'd6;
    localparam logic [IDX_W-1:0] IDX_TMIN  = 4'd7;
    localparam logic [IDX_W-1:0] IDX_THORA = 4'd8;

    // RTC addresses, common to the read and write controllers
    localparam logic [ADDR_W-1:0] ADDR_SEG   = 8'h21;
    localparam logic [ADDR_W-1:0] ADDR_MIN   = 8'h22;
    localparam logic [ADDR_W-1:0] ADDR_HORA  = 8'h23;
    localparam logic [ADDR_W-1:0] ADDR_DIA   = 8'h24;
    localparam logic [ADDR_W-1:0] ADDR_MES   = 8'h25;
    localparam logic [ADDR_W-1:0] ADDR_ANIO  = 8'h26;
    localparam logic [ADDR_W-1:0] ADDR_TSEG  = 8'h41;
    localparam logic [ADDR_W-1:0] ADDR_TMIN  = 8'h42;
    localparam logic [ADDR_W-1:0] ADDR_THORA = 8'h43;
    localparam logic [ADDR_W-1:0] ADDR_NONE  = 8'h00;

endpackage

// File: rtl/control_leer_deco.sv
// Index -> RTC address / hour-register flag decoder, mirror of the write-side decoder.
module deco_leer
    import control_leer_pkg::*;
(
    input  logic [IDX_W-1:0]  i_index,
    output logic [ADDR_W-1:0] o_dir,
    output logic              o_es_hora
);

    // Address lookup; unlisted indices decode to 0x00
    always_comb begin
        o_dir = ADDR_NONE;
        case (i_index)
            IDX_SEG:   o_dir = ADDR_SEG;
            IDX_MIN:   o_dir = ADDR_MIN;
            IDX_HORA:  o_dir = ADDR_HORA;
            IDX_DIA:   o_dir = ADDR_DIA;
            IDX_MES:   o_dir = ADDR_MES;
            IDX_ANIO:  o_dir = ADDR_ANIO;
            IDX_TSEG:  o_dir = ADDR_TSEG;
            IDX_TMIN:  o_dir = ADDR_TMIN;
            IDX_THORA: o_dir = ADDR_THORA;
            default:   o_dir = ADDR_NONE;
        endcase
    end

    assign o_es_hora = (i_index == IDX_HORA) || (i_index == IDX_THORA);

endmodule

// File: rtl/control_leer.sv
// RTC read sequencer: walks the register list, one bus read and one load strobe per register.
module control_leer
    import control_leer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned N_REG   = 9
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              Inicio_L,
    input  logic              Fin_bus,
    input  logic              SF_Timer,
    input  logic              SF_24_12,
    output logic              Rd_bus,
    output logic [ADDR_W-1:0] dir_RTC,
    output logic [IDX_W-1:0]  sel_reg_R,
    output logic              Ld_reg,
    output logic              sel_hora,
    output logic              Fin_L,
    output logic              Err_L
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_index;
    logic [IDX_W-1:0]   w_index_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_timer;
    logic               w_timer_nxt;
    logic [IDX_W-1:0]   w_last;

    logic               r_rd;
    logic               r_ld;
    logic               r_hora;
    logic               r_fin;
    logic               r_err;
    logic [ADDR_W-1:0]  r_dir;
    logic               w_rd_nxt;
    logic               w_ld_nxt;
    logic               w_hora_nxt;
    logic               w_fin_nxt;
    logic               w_err_nxt;
    logic [ADDR_W-1:0]  w_dir_nxt;
    logic               w_es_hora_nxt;

    // Timer registers extend the list only when latched at start
    assign w_last = r_timer ? IDX_W'(N_REG - 1) : IDX_ANIO;

    // Decode of the upcoming index so address and hour flag register with it
    deco_leer u_deco (
        .i_index   (w_index_nxt),
        .o_dir     (w_dir_nxt),
        .o_es_hora (w_es_hora_nxt)
    );

    // State, index, wait counter and timer-mode latch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_index <= '0;
            r_cnt   <= '0;
            r_timer <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_cnt   <= w_cnt_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Next-state logic; Fin_bus beats the timeout on the last wait cycle
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_cnt_nxt   = r_cnt;
        w_timer_nxt = r_timer;
        case (r_state)
            IDLE: begin
                if (Inicio_L) begin
                    w_state_nxt = REQ;
                    w_index_nxt = '0;
                    w_timer_nxt = SF_Timer;
                end
            end
            REQ: begin
                w_cnt_nxt   = '0;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (Fin_bus) begin
                    w_state_nxt = LOAD;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt = ABORT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            LOAD: begin
                if (r_index == w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_index_nxt = r_index + IDX_W'(1);
                    w_state_nxt = REQ;
                end
            end
            DONE:    w_state_nxt = IDLE;
            ABORT:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Moore outputs of the upcoming state, registered below
    always_comb begin
        w_rd_nxt   = 1'b0;
        w_ld_nxt   = 1'b0;
        w_hora_nxt = 1'b0;
        w_fin_nxt  = 1'b0;
        w_err_nxt  = 1'b0;
        case (w_state_nxt)
            REQ:  w_rd_nxt = 1'b1;
            LOAD: begin
                w_ld_nxt   = 1'b1;
                w_hora_nxt = SF_24_12 & w_es_hora_nxt;
            end
            DONE: w_fin_nxt = 1'b1;
            ABORT: begin
                w_fin_nxt = 1'b1;
                w_err_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd   <= 1'b0;
            r_ld   <= 1'b0;
            r_hora <= 1'b0;
            r_fin  <= 1'b0;
            r_err  <= 1'b0;
            r_dir  <= ADDR_SEG;
        end else begin
            r_rd   <= w_rd_nxt;
            r_ld   <= w_ld_nxt;
            r_hora <= w_hora_nxt;
            r_fin  <= w_fin_nxt;
            r_err  <= w_err_nxt;
            r_dir  <= w_dir_nxt;
        end
    end

    assign Rd_bus    = r_rd;
    assign Ld_reg    = r_ld;
    assign sel_hora  = r_hora;
    assign Fin_L     = r_fin;
    assign Err_L     = r_err;
    assign dir_RTC   = r_dir;
    assign sel_reg_R = r_index;

endmodule

// File: tb/tb_control_leer.sv
// Directed bench for control_leer: cycle numbers are relative to the cycle Inicio_L is driven (cycle 0).
module tb_control_leer;

    logic       clk = 1'b0;
    logic       reset;
    logic       Inicio_L;
    logic       Fin_bus;
    logic       SF_Timer;
    logic       SF_24_12;
    logic       Rd_bus;
    logic [7:0] dir_RTC;
    logic [3:0] sel_reg_R;
    logic       Ld_reg;
    logic       sel_hora;
    logic       Fin_L;
    logic       Err_L;

    int n_checks = 0;
    int n_fail   = 0;

    // Results of one sequence
    int         s_nrd;
    int         s_nld;
    int         s_nfin;
    int         s_fincyc;
    int         s_bad_hora;
    logic       s_err;
    logic [8:0] s_horamask;
    logic [7:0] s_rdaddr [16];
    logic [3:0] s_ldidx  [16];
    logic [7:0] s_ldaddr [16];
    logic       act;

    always #5 clk = ~clk;

    control_leer #(.TIMEOUT(255), .N_REG(9)) dut (
        .clk       (clk),
        .reset     (reset),
        .Inicio_L  (Inicio_L),
        .Fin_bus   (Fin_bus),
        .SF_Timer  (SF_Timer),
        .SF_24_12  (SF_24_12),
        .Rd_bus    (Rd_bus),
        .dir_RTC   (dir_RTC),
        .sel_reg_R (sel_reg_R),
        .Ld_reg    (Ld_reg),
        .sel_hora  (sel_hora),
        .Fin_L     (Fin_L),
        .Err_L     (Err_L)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_addr(input int i);
        logic [7:0] a;
        if (i < 6) a = 8'h21 + 8'(i);
        else       a = 8'h41 + 8'(i - 6);
        return a;
    endfunction

    // Run one read sequence; Fin_bus answers 'delay' cycles after each Rd_bus unless the index is hold_idx
    task automatic run_seq(input int delay, input int hold_idx, input bit timer, input bit fmt,
                           input bit noise, input int budget);
        int cyc;
        int fin_due;
        bit done;
        s_nrd = 0; s_nld = 0; s_nfin = 0; s_fincyc = -1; s_bad_hora = 0;
        s_err = 1'b0; s_horamask = '0;
        SF_Timer = timer; SF_24_12 = fmt; Fin_bus = 1'b0; Inicio_L = 1'b1;
        tick;
        Inicio_L = 1'b0;
        cyc = 1; fin_due = -1; done = 1'b0;
        while (!done && cyc < budget) begin
            if (Rd_bus) begin
                if (s_nrd < 16) s_rdaddr[s_nrd] = dir_RTC;
                s_nrd++;
                if (int'(sel_reg_R) != hold_idx) fin_due = cyc + delay;
            end
            if (Ld_reg) begin
                if (s_nld < 16) begin
                    s_ldidx[s_nld]  = sel_reg_R;
                    s_ldaddr[s_nld] = dir_RTC;
                end
                s_nld++;
                if (sel_hora && sel_reg_R < 4'd9) s_horamask[sel_reg_R] = 1'b1;
            end else if (sel_hora) begin
                s_bad_hora++;
            end
            if (Fin_L) begin
                s_fincyc = cyc;
                s_err    = Err_L;
                s_nfin++;
                done = 1'b1;
            end
            Fin_bus  = (cyc == fin_due) || (noise && Rd_bus);
            Inicio_L = noise && !done && (cyc % 4 == 2);
            if (noise) SF_Timer = cyc[0];
            tick;
            cyc++;
        end
        Fin_bus = 1'b0; Inicio_L = 1'b0; SF_Timer = timer;
        repeat (4) begin
            if (Fin_L)  s_nfin++;
            if (Rd_bus) s_nrd++;
            if (Ld_reg) s_nld++;
            tick;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; Inicio_L = 1'b0; Fin_bus = 1'b0; SF_Timer = 1'b0; SF_24_12 = 1'b0;
        repeat (3) tick;

        // Reset state
        check("rst_strobes", 32'({Rd_bus, Ld_reg, sel_hora, Fin_L, Err_L}), 32'h0);
        check("rst_sel_reg", 32'(sel_reg_R), 32'h0);
        check("rst_dir", 32'(dir_RTC), 32'h21);
        reset = 1'b0;
        tick;

        // Spurious Fin_bus while idle
        act = 1'b0;
        Fin_bus = 1'b1;
        repeat (3) begin tick; act |= Rd_bus | Ld_reg | Fin_L | Err_L; end
        Fin_bus = 1'b0;
        tick;
        check("idle_finbus", 32'(act), 32'h0);

        // 1: six registers, Fin_bus two cycles after each request
        run_seq(2, -1, 1'b0, 1'b0, 1'b0, 200);
        check("t1_nrd", 32'(s_nrd), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("t1_rdaddr%0d", i), 32'(s_rdaddr[i]), 32'(exp_addr(i)));
        check("t1_nld", 32'(s_nld), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("t1_ldidx%0d", i), 32'(s_ldidx[i]), 32'(i));
        for (int i = 0; i < 6; i++) check($sformatf("t1_ldaddr%0d", i), 32'(s_ldaddr[i]), 32'(exp_addr(i)));
        check("t1_fincyc", 32'(s_fincyc), 32'd25);
        check("t1_nfin", 32'(s_nfin), 32'd1);
        check("t1_err", 32'(s_err), 32'h0);

        // 2: timer registers included, immediate Fin_bus; Fin_L in the 29th cycle counting Inicio_L's
        run_seq(1, -1, 1'b1, 1'b0, 1'b0, 200);
        check("t2_nld", 32'(s_nld), 32'd9);
        for (int i = 0; i < 9; i++) check($sformatf("t2_ldaddr%0d", i), 32'(s_ldaddr[i]), 32'(exp_addr(i)));
        check("t2_fincyc", 32'(s_fincyc), 32'd28);
        check("t2_horamask", 32'(s_horamask), 32'h0);
        check("t2_err", 32'(s_err), 32'h0);

        // 3: 12 h format flags only the two hour registers
        run_seq(1, -1, 1'b1, 1'b1, 1'b0, 200);
        check("t3_nld", 32'(s_nld), 32'd9);
        check("t3_horamask", 32'(s_horamask), 32'h104);
        check("t3_bad_hora", 32'(s_bad_hora), 32'h0);

        // 4: no answer for index 3 -> abort after 255 wait cycles
        run_seq(1, 3, 1'b0, 1'b0, 1'b0, 400);
        check("t4_nrd", 32'(s_nrd), 32'd4);
        check("t4_nld", 32'(s_nld), 32'd3);
        check("t4_lastld", 32'(s_ldidx[2]), 32'd2);
        check("t4_fincyc", 32'(s_fincyc), 32'd266);
        check("t4_err", 32'(s_err), 32'h1);
        check("t4_nfin", 32'(s_nfin), 32'd1);

        // 5: extra Inicio_L, Fin_bus during REQ, SF_Timer toggling
        run_seq(2, -1, 1'b0, 1'b0, 1'b1, 200);
        check("t5_nrd", 32'(s_nrd), 32'd6);
        check("t5_nld", 32'(s_nld), 32'd6);
        check("t5_fincyc", 32'(s_fincyc), 32'd25);
        check("t5_nfin", 32'(s_nfin), 32'd1);
        check("t5_err", 32'(s_err), 32'h0);

        // 6: reset while waiting on index 4
        SF_Timer = 1'b0; Fin_bus = 1'b1; Inicio_L = 1'b1;
        tick;
        Inicio_L = 1'b0;
        repeat (11) tick;
        Fin_bus = 1'b0;
        tick;
        check("t6_req", 32'({Rd_bus, sel_reg_R}), 32'h14);
        tick;
        check("t6_wait", 32'({Rd_bus, Ld_reg, Fin_L}), 32'h0);
        check("t6_wait_dir", 32'(dir_RTC), 32'h25);
        reset = 1'b1;
        tick;
        check("t6_rst_strobes", 32'({Rd_bus, Ld_reg, sel_hora, Fin_L, Err_L}), 32'h0);
        check("t6_rst_idx", 32'({sel_reg_R, dir_RTC}), 32'h021);
        reset = 1'b0;
        act = 1'b0;
        repeat (5) begin act |= Rd_bus | Ld_reg | Fin_L | Err_L; tick; end
        check("t6_quiet", 32'(act), 32'h0);
        run_seq(1, -1, 1'b0, 1'b0, 1'b0, 200);
        check("t6_first_idx", 32'(s_ldidx[0]), 32'h0);
        check("t6_nld", 32'(s_nld), 32'd6);
        check("t6_fincyc", 32'(s_fincyc), 32'd19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
